// File: rtl/keypad_event_controller_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad event controller:
//   NUM_KEYS        number of keys in the matrix (4x4)
//   KEY_CODE_W      width of a key index
//   ROW_IDLE_SCAN   kb_row value that marks the first row of a scan
//   state_t         drain FSM state encoding
//   lowest_set_index  index of the least-significant set bit of a key mask
// ---------------------------------------------------------------------------
package keypad_pkg;

    localparam int NUM_KEYS   = 16;
    localparam int KEY_CODE_W = 4;
    localparam logic [3:0] ROW_IDLE_SCAN = 4'b1110;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Returns 0 for an all-zero mask; callers only use it on non-zero masks.
    function automatic logic [KEY_CODE_W-1:0] lowest_set_index(input logic [NUM_KEYS-1:0] v);
        logic [KEY_CODE_W-1:0] idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = KEY_CODE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_event_controller_if.sv
// ---------------------------------------------------------------------------
// keypad_event_if
// Key-event stream between the keypad controller (master) and its consumer
// (slave, e.g. CPU or display logic).
//   key_code      head-of-queue key index
//   key_valid     queue non-empty
//   key_ready     consumer accepts the head when key_valid is also high
//   fifo_count    queue occupancy
//   overflow      sticky flag, an event was dropped
//   clr_overflow  clears overflow
// ---------------------------------------------------------------------------
interface keypad_event_if
    import keypad_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) ();

    logic [KEY_CODE_W-1:0]         key_code;
    logic                          key_valid;
    logic                          key_ready;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;
    logic                          clr_overflow;

    modport master (
        output key_code,
        output key_valid,
        output fifo_count,
        output overflow,
        input  key_ready,
        input  clr_overflow
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  fifo_count,
        input  overflow,
        output key_ready,
        output clr_overflow
    );

endinterface

// File: rtl/keypad_event_controller_fifo.sv
// ---------------------------------------------------------------------------
// keypad_event_fifo
// Small synchronous FIFO for key events. Head data is read combinationally
// from registered storage, so a write becomes visible one cycle later.
//   clk, reset_n  clock, synchronous active-low reset
//   push, push_data  write strobe (caller guarantees !full or same-cycle pop)
//   pop           read strobe (caller guarantees !empty)
//   full, empty, count  status
//   head          entry at the read pointer, 0 while empty
// ---------------------------------------------------------------------------
module keypad_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;

    // Storage needs no reset: nothing is read from it while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Pointers are exactly log2(DEPTH) wide, so increments wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head  = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/keypad_event_controller.sv
// ---------------------------------------------------------------------------
// keypad_event_controller
// Detects scan boundaries from kb_row, samples and debounces the active-low
// keys vector once per scan, and turns each new press into a 4-bit key code
// queued behind a valid/ready handshake.
//   clk       system clock (same as the decoder's scan clock)
//   reset_n   synchronous active-low reset
//   keys      raw decoder output, active-low, bit 4*row+col
//   kb_row    decoder row drive, one-hot-low
//   key_held  debounced key state, active-high
//   evt       event stream (keypad_event_if.master): key_code, key_valid,
//             key_ready, fifo_count, overflow, clr_overflow
// Optional build macro: KEYPAD_AUTOREPEAT_EN adds auto-repeat of a lone
// held key (REPEAT_DELAY / REPEAT_PERIOD scans).
// ---------------------------------------------------------------------------
module keypad_event_controller
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 4
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY   = 20,
    parameter int REPEAT_PERIOD  = 5
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_KEYS-1:0]  keys,
    input  logic [3:0]           kb_row,
    output logic [NUM_KEYS-1:0]  key_held,
    keypad_event_if.master       evt
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE_SCANS);

    logic [3:0]            prev_row_reg;
    logic [NUM_KEYS-1:0]   last_sample_reg;
    logic [3:0]            deb_cnt_reg;
    logic [3:0]            deb_cnt_next;
    logic [NUM_KEYS-1:0]   key_held_reg;
    logic [NUM_KEYS-1:0]   block_reg;
    logic [NUM_KEYS-1:0]   pending_reg;
    logic [NUM_KEYS-1:0]   pending_next;
    state_t                state_reg;
    state_t                state_next;
    logic                  overflow_reg;

    logic                  scan_tick;
    logic [NUM_KEYS-1:0]   sample;
    logic                  held_update;
    logic [NUM_KEYS-1:0]   new_mask;
    logic [NUM_KEYS-1:0]   repeat_mask;
    logic [NUM_KEYS-1:0]   req_mask;

    logic                  push;
    logic [KEY_CODE_W-1:0] push_code;
    logic                  push_ok;
    logic                  pop;
    logic                  drop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [KEY_CODE_W-1:0] fifo_head;

    // ---------------- scan boundary and debounce ----------------
    assign scan_tick = (prev_row_reg != ROW_IDLE_SCAN) && (kb_row == ROW_IDLE_SCAN);
    assign sample    = ~keys;

    always_comb begin
        deb_cnt_next = deb_cnt_reg;
        if (scan_tick) begin
            if (sample == last_sample_reg) begin
                deb_cnt_next = (deb_cnt_reg >= DEB_MAX) ? DEB_MAX : deb_cnt_reg + 1'b1;
            end else begin
                deb_cnt_next = 4'd1;
            end
        end
    end

    assign held_update = scan_tick && (deb_cnt_next == DEB_MAX);

    // A key is blocked from producing a press event until the debounced
    // state has shown it released at least once since reset, so keys held
    // across reset do not generate events.
    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_new_mask
            assign new_mask[gi] = held_update & sample[gi] & ~key_held_reg[gi] & ~block_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_row_reg    <= 4'b1111;
            last_sample_reg <= '0;
            deb_cnt_reg     <= '0;
            key_held_reg    <= '0;
            block_reg       <= '1;
        end else begin
            prev_row_reg <= kb_row;
            deb_cnt_reg  <= deb_cnt_next;
            if (scan_tick && (sample != last_sample_reg)) begin
                last_sample_reg <= sample;
            end
            if (held_update) begin
                key_held_reg <= sample;
                block_reg    <= block_reg & sample;
            end
        end
    end

    // ---------------- optional auto-repeat ----------------
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

    logic [RPT_W-1:0] rpt_cnt_reg;
    logic [RPT_W-1:0] rpt_cnt_inc;
    logic             held_changed;
    logic             single_held;
    logic             repeat_fire;

    assign held_changed = held_update && (sample != key_held_reg);
    assign single_held  = (key_held_reg != '0)
                       && ((key_held_reg & (key_held_reg - 1'b1)) == '0)
                       && ((key_held_reg & block_reg) == '0);
    assign rpt_cnt_inc  = rpt_cnt_reg + 1'b1;
    assign repeat_fire  = scan_tick && single_held && !held_changed
                       && ((rpt_cnt_inc == RPT_W'(REPEAT_DELAY))
                        || (rpt_cnt_inc == RPT_W'(REPEAT_DELAY + REPEAT_PERIOD)));

    // After the first repeat the counter folds back to REPEAT_DELAY so each
    // further REPEAT_PERIOD ticks fire again.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rpt_cnt_reg <= '0;
        end else if (held_changed || !single_held) begin
            rpt_cnt_reg <= '0;
        end else if (scan_tick) begin
            rpt_cnt_reg <= (rpt_cnt_inc == RPT_W'(REPEAT_DELAY + REPEAT_PERIOD))
                         ? RPT_W'(REPEAT_DELAY) : rpt_cnt_inc;
        end
    end

    assign repeat_mask = repeat_fire ? key_held_reg : '0;
`else
    assign repeat_mask = '0;
`endif

    assign req_mask = new_mask | repeat_mask;

    // ---------------- drain FSM ----------------
    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        push         = 1'b0;
        push_code    = '0;
        case (state_reg)
            IDLE: begin
                if (req_mask != '0) begin
                    pending_next = pending_reg | req_mask;
                    state_next   = DRAIN;
                end
            end
            DRAIN: begin
                push         = 1'b1;
                push_code    = lowest_set_index(pending_reg);
                // The bit is cleared whether or not the FIFO took the event.
                pending_next = (pending_reg & ~(NUM_KEYS'(1) << push_code)) | req_mask;
                if (pending_next == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
        end
    end

    // ---------------- event FIFO and overflow ----------------
    assign pop     = !fifo_empty && evt.key_ready;
    assign push_ok = push && (!fifo_full || pop);
    assign drop    = push && fifo_full && !pop;

    keypad_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KEY_CODE_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_ok),
        .push_data (push_code),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // Setting wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (evt.clr_overflow) begin
            overflow_reg <= 1'b0;
        end
    end

    assign key_held       = key_held_reg;
    assign evt.key_code   = fifo_head;
    assign evt.key_valid  = !fifo_empty;
    assign evt.fifo_count = fifo_count;
    assign evt.overflow   = overflow_reg;

endmodule
